tx_chan_router: RTL and testbench

Packet router between the TX USB packer and the per-channel packet RAMs. It takes the 32-bit word stream from the packer (one 128-word in-band packet at a time) and decodes the channel field of each header word. It steers the whole packet into the matching channel RAM, with the control channel going to the command RAM, and pulses that RAM's commit strobe at the end of the packet. Packets for an unknown channel, or for a RAM without space, are consumed, discarded and counted.

---
 rtl/tx_inband_pkg.sv | 37 +++
 rtl/tx_chan_router.sv | 154 +++++++++++++++
 tb/tb_tx_chan_router.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_inband_pkg.sv
// Shared in-band packet definitions for the TX path: header field
// positions, packet geometry, command-channel code and router states.
package tx_inband_pkg;

    // Header word field positions
    localparam int unsigned CHAN_HI = 20;
    localparam int unsigned CHAN_LO = 16;
    localparam int unsigned LEN_HI  = 8;
    localparam int unsigned LEN_LO  = 0;

    localparam int unsigned CHAN_W  = CHAN_HI - CHAN_LO + 1;
    localparam int unsigned LEN_W   = LEN_HI - LEN_LO + 1;

    // 32-bit words per packet, header included
    localparam int unsigned PKT_WORDS = 128;

    // Header channel code that selects the command RAM
    localparam logic [CHAN_W-1:0] CMD_CHAN = 5'h1F;

    // Router packet-handling states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } rtr_state_t;

    // Channel field of a header word
    function automatic logic [CHAN_W-1:0] hdr_chan(input logic [31:0] w);
        return w[CHAN_HI:CHAN_LO];
    endfunction

    // Payload length field of a header word (carried through untouched)
    function automatic logic [LEN_W-1:0] hdr_len(input logic [31:0] w);
        return w[LEN_HI:LEN_LO];
    endfunction

endpackage

// File: rtl/tx_chan_router.sv
// Steers each 128-word in-band packet from the TX packer into its channel
// RAM (or the command RAM), commits it at end of packet, and discards and
// counts packets for unknown channels or full RAMs.
module tx_chan_router
    import tx_inband_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 2
) (
    input  logic                txclk,
    input  logic                reset,
    input  logic [31:0]         usbdata_final,
    input  logic                WR_final,
    input  logic [NUM_CHAN:0]   chan_have_space,
    output logic [31:0]         ram_data,
    output logic [NUM_CHAN:0]   WR_channel,
    output logic [NUM_CHAN:0]   WR_done_channel,
    output logic [15:0]         dropped_pkts,
    output logic                busy
);

    localparam int unsigned NOUT     = NUM_CHAN + 1;
    localparam int unsigned IDX_W    = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [7:0]  LAST_CNT = 8'(PKT_WORDS);

    rtr_state_t        state, state_nxt;
    logic [7:0]        word_cnt, word_cnt_nxt;
    logic [7:0]        cnt_inc;
    logic              last_word;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [NUM_CHAN:0] wr_nxt;
    logic [NUM_CHAN:0] done_pend, done_pend_nxt;
    logic              drop_inc;

    logic [CHAN_W-1:0] hdr_c;
    logic              hdr_valid;
    logic [IDX_W-1:0]  hdr_idx;

    function automatic logic [NUM_CHAN:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_CHAN:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // Decode the channel field of the current word into a RAM index
    always_comb begin
        hdr_c     = hdr_chan(usbdata_final);
        hdr_valid = 1'b0;
        hdr_idx   = '0;
        if (32'(hdr_c) < NUM_CHAN) begin
            hdr_valid = 1'b1;
            hdr_idx   = IDX_W'(hdr_c);
        end else if (hdr_c == CMD_CHAN) begin
            hdr_valid = 1'b1;
            hdr_idx   = IDX_W'(NUM_CHAN);
        end
    end

    // Next-state, word counter, write strobe and commit scheduling
    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        idx_nxt       = idx;
        wr_nxt        = '0;
        done_pend_nxt = '0;
        drop_inc      = 1'b0;
        cnt_inc       = word_cnt + 8'd1;
        last_word     = (cnt_inc == LAST_CNT);

        case (state)
            IDLE: begin
                word_cnt_nxt = '0;
                if (WR_final) begin
                    word_cnt_nxt = 8'd1;
                    // Space is only looked at here: the RAM reserves a whole
                    // packet, so later deassertions must not abort it.
                    if (hdr_valid && chan_have_space[hdr_idx]) begin
                        idx_nxt   = hdr_idx;
                        wr_nxt    = onehot(hdr_idx);
                        state_nxt = ROUTE;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end

            ROUTE: begin
                if (WR_final) begin
                    wr_nxt       = onehot(idx);
                    word_cnt_nxt = cnt_inc;
                    if (last_word) begin
                        // Commit goes out one cycle after the last write
                        done_pend_nxt = onehot(idx);
                        word_cnt_nxt  = '0;
                        state_nxt     = IDLE;
                    end
                end
            end

            DROP: begin
                if (WR_final) begin
                    word_cnt_nxt = cnt_inc;
                    if (last_word) begin
                        drop_inc     = 1'b1;
                        word_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end
                end
            end

            default: begin
                word_cnt_nxt = '0;
                state_nxt    = IDLE;
            end
        endcase
    end

    // FSM state, counter, latched index and pending commit
    always_ff @(posedge txclk) begin
        if (reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            idx       <= '0;
            done_pend <= '0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            idx       <= idx_nxt;
            done_pend <= done_pend_nxt;
        end
    end

    // Registered RAM-side outputs and drop counter
    always_ff @(posedge txclk) begin
        if (reset) begin
            ram_data        <= '0;
            WR_channel      <= '0;
            WR_done_channel <= '0;
            dropped_pkts    <= '0;
        end else begin
            WR_channel      <= wr_nxt;
            WR_done_channel <= done_pend;
            if (wr_nxt != '0) begin
                ram_data <= usbdata_final;
            end
            if (drop_inc && (dropped_pkts != '1)) begin
                dropped_pkts <= dropped_pkts + 16'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_chan_router.sv
// Self-checking bench for tx_chan_router: table-driven packets plus
// hand-written corner sequences, with a write/commit scoreboard.
module tb_tx_chan_router;

    localparam int PKT_W = 128;

    logic        txclk;
    logic        reset;
    logic [31:0] usbdata_final;
    logic        WR_final;
    logic [2:0]  chan_have_space;
    logic [31:0] ram_data;
    logic [2:0]  WR_channel;
    logic [2:0]  WR_done_channel;
    logic [15:0] dropped_pkts;
    logic        busy;

    tx_chan_router #(.NUM_CHAN(2)) dut (
        .txclk           (txclk),
        .reset           (reset),
        .usbdata_final   (usbdata_final),
        .WR_final        (WR_final),
        .chan_have_space (chan_have_space),
        .ram_data        (ram_data),
        .WR_channel      (WR_channel),
        .WR_done_channel (WR_done_channel),
        .dropped_pkts    (dropped_pkts),
        .busy            (busy)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] data;
        bit          last;
    } wr_t;

    typedef struct {
        logic [4:0] chan;
        logic [2:0] space;
        logic [2:0] exp_mask;   // 0 means the packet must be dropped
    } vec_t;

    wr_t         wq[$];
    logic [2:0]  done_due;
    logic [31:0] pdat[PKT_W];
    int          n_cmp;
    int          n_bad;
    int          exp_drops;
    int          n_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard: every write and commit is checked one edge later
    initial done_due = '0;
    always @(negedge txclk) begin
        wr_t e;
        if (done_due != '0 || WR_done_channel != '0) begin
            n_cmp++;
            if (WR_done_channel !== done_due) begin
                n_bad++;
                $display("FAIL wr_done: got %b want %b (t=%0t)", WR_done_channel, done_due, $time);
            end else begin
                n_done++;
            end
        end
        done_due = '0;
        if (WR_channel != '0) begin
            n_cmp++;
            if (wq.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got %b data %h want none (t=%0t)", WR_channel, ram_data, $time);
            end else begin
                e = wq.pop_front();
                if (WR_channel !== e.mask || ram_data !== e.data) begin
                    n_bad++;
                    $display("FAIL wr_word: got %b/%h want %b/%h (t=%0t)",
                             WR_channel, ram_data, e.mask, e.data, $time);
                end
                if (e.last) done_due = e.mask;
            end
        end
    end

    task automatic fill(input logic [4:0] chan);
        for (int i = 0; i < PKT_W; i++) pdat[i] = $urandom();
        pdat[0][20:16] = chan;
        pdat[0][8:0]   = 9'd508;
    endtask

    // Send pdat as one packet; gaps between words are gmin..gmax idle cycles
    task automatic send_pkt(input logic [2:0] space, input logic [2:0] exp_mask,
                            input int gmin, input int gmax,
                            input int space_fall, input int abort_at);
        chan_have_space = space;
        for (int i = 0; i < PKT_W; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                repeat (2) @(posedge txclk);
                #1;
                reset     = 1'b0;
                exp_drops = 0;
                return;
            end
            if (i == space_fall) chan_have_space[0] = 1'b0;
            if (i == 1) chk("busy_in_pkt", 32'(busy), 32'd1);
            usbdata_final = pdat[i];
            WR_final      = 1'b1;
            if (exp_mask != '0)
                wq.push_back('{mask: exp_mask, data: pdat[i], last: (i == PKT_W - 1)});
            @(posedge txclk);
            #1;
            WR_final = 1'b0;
            if (i == PKT_W - 1) chk("busy_after_last", 32'(busy), 32'd0);
            repeat ($urandom_range(gmax, gmin)) begin
                @(posedge txclk);
                #1;
            end
        end
        if (exp_mask == '0 && exp_drops < 16'hFFFF) exp_drops++;
    endtask

    task automatic settle();
        repeat (4) begin
            @(posedge txclk);
            #1;
        end
        chk("scoreboard_drained", 32'(wq.size()), 32'd0);
        chk("dropped_pkts", 32'(dropped_pkts), 32'(exp_drops));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   done0;
        tbl[0] = '{chan: 5'd0,    space: 3'b111, exp_mask: 3'b001};
        tbl[1] = '{chan: 5'h1F,   space: 3'b111, exp_mask: 3'b100};
        tbl[2] = '{chan: 5'd1,    space: 3'b101, exp_mask: 3'b000};
        tbl[3] = '{chan: 5'd5,    space: 3'b111, exp_mask: 3'b000};
        tbl[4] = '{chan: 5'd0,    space: 3'b111, exp_mask: 3'b001};
        tbl[5] = '{chan: 5'd1,    space: 3'b010, exp_mask: 3'b010};
        tbl[6] = '{chan: 5'd2,    space: 3'b111, exp_mask: 3'b000};
        tbl[7] = '{chan: 5'h1F,   space: 3'b011, exp_mask: 3'b000};

        n_cmp = 0; n_bad = 0; exp_drops = 0; n_done = 0;
        reset = 1'b1; WR_final = 1'b0; usbdata_final = '0; chan_have_space = 3'b111;
        repeat (3) @(posedge txclk);
        #1;
        chk("rst_ram_data", ram_data, 32'd0);
        chk("rst_wr", 32'(WR_channel), 32'd0);
        chk("rst_done", 32'(WR_done_channel), 32'd0);
        chk("rst_dropped", 32'(dropped_pkts), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge txclk);
        #1;

        // Table-driven packets
        for (int k = 0; k < 8; k++) begin
            fill(tbl[k].chan);
            send_pkt(tbl[k].space, tbl[k].exp_mask, 1, 3, -1, -1);
            settle();
        end

        // Space for channel 0 falls at word 60: whole packet still commits
        done0 = n_done;
        fill(5'd0);
        send_pkt(3'b111, 3'b001, 1, 2, 60, -1);
        settle();
        chk("space_fall_commit", 32'(n_done - done0), 32'd1);

        // Reset at word 50 of a channel-1 packet: no commit, counter at reset value
        done0 = n_done;
        fill(5'd1);
        send_pkt(3'b111, 3'b010, 1, 1, -1, 50);
        settle();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_commit", 32'(n_done - done0), 32'd0);
        fill(5'd0);
        send_pkt(3'b111, 3'b001, 1, 2, -1, -1);
        settle();

        // Back-to-back packets on channel 0 with minimum spacing
        done0 = n_done;
        fill(5'd0);
        send_pkt(3'b111, 3'b001, 1, 1, -1, -1);
        fill(5'd0);
        send_pkt(3'b111, 3'b001, 1, 1, -1, -1);
        settle();
        chk("b2b_commits", 32'(n_done - done0), 32'd2);

        // Same packet contents replayed with random 1-5 cycle gaps
        fill(5'd0);
        send_pkt(3'b111, 3'b001, 1, 1, -1, -1);
        send_pkt(3'b111, 3'b001, 1, 5, -1, -1);
        settle();
        chk("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
